// File: rtl/glitc_seq_pkg.sv
// rtl/glitc_seq_pkg.sv - state, error-code and counter-width definitions for the GLITC sequencer
package glitc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET      = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_WAIT_VALID = 3'd3,
    ST_RUN        = 3'd4,
    ST_FLUSH      = 3'd5,
    ST_FAIL       = 3'd6
  } seq_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_LOST    = 2'd2;
  localparam logic [1:0] ERR_FLUSH   = 2'd3;

  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_SETTLE_CYCLES  = 32;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  // The counter only ever holds (cycles - 1), so log2 of the largest period suffices.
  function automatic int seq_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int SEQ_CNT_W = seq_cnt_width(DEF_RST_CYCLES, DEF_SETTLE_CYCLES, DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/glitc_seq_timer.sv
// rtl/glitc_seq_timer.sv - loadable down-counter with expired flag
module glitc_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/glitc_datapath_sequencer.sv
// rtl/glitc_datapath_sequencer.sv - bring-up, monitoring and shutdown sequencer for the IN_FIFO buffers
module glitc_datapath_sequencer
  import glitc_seq_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       SYSCLK,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       fifo_valid_i,
  output logic       fifo_rst_o,
  output logic       fifo_en_o,
  output logic       running_o,
  output logic       busy_o,
  output logic       error_o,
  output logic [1:0] err_code_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lost_cnt_o
);

  localparam int CNT_W = seq_cnt_width(RST_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RST_LD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       MAX_R      = 4'(MAX_RETRIES);

  seq_state_e state_q, state_d;
  logic [3:0] retry_q, retry_d;
  logic [1:0] err_q, err_d;
  logic [7:0] lost_q, lost_d;
  logic       fifo_rst_q, fifo_rst_d;
  logic       fifo_en_q, fifo_en_d;
  logic       running_q, running_d;
  logic       busy_q, busy_d;
  logic       error_q, error_d;
  logic       retry_evt;
  logic       tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic       tmr_expired;

  glitc_seq_timer #(.W(CNT_W)) u_timer (
    .clk        (SYSCLK),
    .rst_n_i    (rst_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge SYSCLK) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      retry_q    <= '0;
      err_q      <= ERR_NONE;
      lost_q     <= '0;
      fifo_rst_q <= 1'b0;
      fifo_en_q  <= 1'b0;
      running_q  <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      lost_q     <= lost_d;
      fifo_rst_q <= fifo_rst_d;
      fifo_en_q  <= fifo_en_d;
      running_q  <= running_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  // Priority inside each state: stop, then the valid event, then counter expiry.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    err_d     = err_q;
    lost_d    = lost_q;
    retry_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          state_d = ST_RESET;
          retry_d = '0;
          err_d   = ERR_NONE;
        end
      end
      ST_RESET: begin
        if (stop_i)           state_d = ST_IDLE;
        else if (tmr_expired) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (stop_i)           state_d = ST_IDLE;
        else if (tmr_expired) state_d = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        if (stop_i) begin
          state_d = ST_FLUSH;
        end else if (fifo_valid_i) begin
          state_d = ST_RUN;
        end else if (tmr_expired) begin
          err_d     = ERR_TIMEOUT;
          retry_evt = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_FLUSH;
        end else if (!fifo_valid_i) begin
          err_d     = ERR_LOST;
          retry_evt = 1'b1;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      ST_FLUSH: begin
        if (!fifo_valid_i) begin
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          err_d   = ERR_FLUSH;
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (start_i) begin
          state_d = ST_RESET;
          retry_d = '0;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (retry_evt) begin
      if (retry_q < MAX_R) begin
        retry_d = retry_q + 4'd1;
        state_d = ST_RESET;
      end else begin
        state_d = ST_FAIL;
      end
    end
  end

  // Outputs are registered decodes of the next state, so they track state_q exactly.
  always_comb begin
    tmr_load     = (state_d != state_q);
    tmr_load_val = '0;
    case (state_d)
      ST_RESET:      tmr_load_val = RST_LD;
      ST_SETTLE:     tmr_load_val = SETTLE_LD;
      ST_WAIT_VALID: tmr_load_val = TIMEOUT_LD;
      ST_FLUSH:      tmr_load_val = TIMEOUT_LD;
      default:       tmr_load_val = '0;
    endcase
    fifo_rst_d = (state_d == ST_RESET);
    fifo_en_d  = (state_d == ST_WAIT_VALID) || (state_d == ST_RUN);
    running_d  = (state_d == ST_RUN);
    busy_d     = (state_d == ST_RESET) || (state_d == ST_SETTLE) ||
                 (state_d == ST_WAIT_VALID) || (state_d == ST_FLUSH);
    error_d    = (state_d == ST_FAIL);
  end

  assign fifo_rst_o  = fifo_rst_q;
  assign fifo_en_o   = fifo_en_q;
  assign running_o   = running_q;
  assign busy_o      = busy_q;
  assign error_o     = error_q;
  assign err_code_o  = err_q;
  assign retry_cnt_o = retry_q;
  assign lost_cnt_o  = lost_q;

endmodule

// File: tb/tb_glitc_datapath_sequencer.sv
// tb/tb_glitc_datapath_sequencer.sv - directed self-checking bench for glitc_datapath_sequencer
module tb_glitc_datapath_sequencer;

  logic       SYSCLK = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       fifo_valid_i = 1'b0;
  logic       fifo_rst_o;
  logic       fifo_en_o;
  logic       running_o;
  logic       busy_o;
  logic       error_o;
  logic [1:0] err_code_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lost_cnt_o;

  int checks = 0;
  int failures = 0;
  bit v_auto = 1'b1;
  bit v_drop = 1'b0;
  bit v_never = 1'b0;
  int en_cnt = 0;
  int n, m, k;

  glitc_datapath_sequencer dut (
    .SYSCLK       (SYSCLK),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .fifo_valid_i (fifo_valid_i),
    .fifo_rst_o   (fifo_rst_o),
    .fifo_en_o    (fifo_en_o),
    .running_o    (running_o),
    .busy_o       (busy_o),
    .error_o      (error_o),
    .err_code_o   (err_code_o),
    .retry_cnt_o  (retry_cnt_o),
    .lost_cnt_o   (lost_cnt_o)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  // Buffer model: valid rises on the 5th edge that sees fifo_en_o high, falls once enable drops.
  initial begin : valid_model
    forever begin
      @(posedge SYSCLK);
      #2;
      if (fifo_en_o) en_cnt++;
      else en_cnt = 0;
      if (v_auto) fifo_valid_i = (en_cnt >= 5) && !v_drop && !v_never;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic pick(input int sel);
    case (sel)
      0:       return fifo_rst_o;
      1:       return fifo_en_o;
      2:       return running_o;
      3:       return busy_o;
      4:       return error_o;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({fifo_rst_o, fifo_en_o, running_o, busy_o, error_o,
                err_code_o, retry_cnt_o, lost_cnt_o});
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic lvl,
                          input int budget, output int cyc);
    cyc = 0;
    while (pick(sel) !== lvl && cyc < budget) begin
      tick();
      cyc++;
    end
    check(tag, 32'(pick(sel)), 32'(lvl));
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  task automatic drop_valid();
    v_drop = 1'b1;
    tick();
    v_drop = 1'b0;
  endtask

  initial begin : main
    repeat (3) tick();
    check("reset_outs", all_outs(), 32'd0);
    rst_n_i = 1'b1;
    tick();

    // Normal bring-up
    pulse_start();
    check("t1_rst_lat", 32'(fifo_rst_o), 32'd1);
    n = 0;
    while (fifo_rst_o && n < 100) begin n++; tick(); end
    check("t1_rst_len", n, 16);
    check("t1_settle", {busy_o, fifo_rst_o, fifo_en_o}, 3'b100);
    m = n;
    while (!fifo_en_o && m < 200) begin m++; tick(); end
    check("t1_en_lat", m, 48);
    wait_for("t1_run", 2, 1'b1, 20, k);
    check("t1_run_lat", k, 5);
    check("t1_status", {err_code_o, retry_cnt_o, busy_o}, 7'd0);

    // One-cycle valid loss in RUN
    drop_valid();
    check("t3_retry_state", {fifo_rst_o, fifo_en_o, running_o}, 3'b100);
    check("t3_err", err_code_o, 2);
    check("t3_lost", lost_cnt_o, 1);
    check("t3_retry", retry_cnt_o, 1);
    wait_for("t3_rerun", 2, 1'b1, 200, k);
    check("t3_hold", {err_code_o, retry_cnt_o}, {2'd2, 4'd1});

    // Stop in RUN, valid falls three cycles later
    v_auto = 1'b0;
    fifo_valid_i = 1'b1;
    pulse_stop();
    check("t4_flush", {fifo_en_o, busy_o, running_o}, 3'b010);
    tick();
    tick();
    check("t4_flush_hold", busy_o, 1);
    fifo_valid_i = 1'b0;
    tick();
    check("t4_idle", {busy_o, error_o, fifo_en_o}, 3'b000);
    check("t4_err_hold", err_code_o, 2);
    v_auto = 1'b1;
    pulse_start();
    check("t4_restart_clr", {err_code_o, retry_cnt_o}, 6'd0);
    wait_for("t4_run", 2, 1'b1, 100, k);

    // Stop with valid stuck high -> flush timeout
    v_auto = 1'b0;
    fifo_valid_i = 1'b1;
    pulse_stop();
    n = 0;
    while (!error_o && n < 400) begin n++; tick(); end
    check("t4_flush_tmo", n, 256);
    check("t4_fail", {err_code_o, fifo_rst_o, fifo_en_o, busy_o, running_o}, 6'b110000);

    // Valid never arrives: four timeouts then FAIL
    v_auto = 1'b1;
    v_never = 1'b1;
    pulse_start();
    check("t2_restart", {error_o, fifo_rst_o, err_code_o, retry_cnt_o}, 8'h40);
    for (int i = 0; i < 4; i++) begin
      wait_for("t2_en", 1, 1'b1, 100, k);
      n = 0;
      while (fifo_en_o && n < 400) begin n++; tick(); end
      check("t2_wait_len", n, 256);
      if (i < 3) check("t2_retry", {fifo_rst_o, err_code_o, retry_cnt_o}, {1'b1, 2'd1, 4'(i + 1)});
      else check("t2_fail", {error_o, fifo_rst_o, err_code_o, retry_cnt_o}, {1'b1, 1'b0, 2'd1, 4'd3});
    end
    v_never = 1'b0;
    pulse_start();
    check("t2_clear", {retry_cnt_o, err_code_o, fifo_rst_o}, 7'b0000001);
    wait_for("t2_run", 2, 1'b1, 200, k);

    // Simultaneous start/stop in RUN; start during SETTLE ignored
    start_i = 1'b1;
    stop_i = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i = 1'b0;
    check("t5_both", {fifo_en_o, busy_o, fifo_rst_o, running_o}, 4'b0100);
    wait_for("t5_idle", 3, 1'b0, 20, k);
    pulse_start();
    n = 0;
    while (fifo_rst_o && n < 100) begin n++; tick(); end
    check("t5_rst_len", n, 16);
    m = n;
    while (!fifo_en_o && m < 200) begin
      if (m == 20) start_i = 1'b1;
      m++;
      tick();
      start_i = 1'b0;
    end
    check("t5_settle_start", m, 48);
    wait_for("t5_run", 2, 1'b1, 20, k);

    // Reset mid WAIT_VALID and mid RESET
    drop_valid();
    wait_for("t6_en", 1, 1'b1, 100, k);
    tick();
    tick();
    rst_n_i = 1'b0;
    tick();
    check("t6_rst_wait", all_outs(), 32'd0);
    rst_n_i = 1'b1;
    tick();
    pulse_start();
    tick();
    tick();
    check("t6_in_reset", fifo_rst_o, 1);
    rst_n_i = 1'b0;
    tick();
    check("t6_rst_reset", all_outs(), 32'd0);
    rst_n_i = 1'b1;
    tick();

    // Lost-event counter saturation
    pulse_start();
    for (int e = 1; e <= 300; e++) begin
      wait_for("t6_sat_run", 2, 1'b1, 200, k);
      drop_valid();
      if (error_o) pulse_start();
      if (e == 100 || e == 255 || e == 300) check("t6_lost", lost_cnt_o, (e > 255) ? 255 : e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
